riscv_fetch_queue: RTL

//  Producer side of the instruction decoder: issues in-order IMEM reads, buffers returned words with their PC,
//  and presents one 32-bit instruction per cycle to decode under a valid/ready handshake. Flushes on

---
 rtl/riscv_fetch_queue_pkg.sv | 18 +
 rtl/riscv_fetch_queue_if.sv | 35 +++
 rtl/riscv_fetch_queue_sync_fifo.sv | 46 ++++
 rtl/riscv_fetch_queue.sv | 133 +++++++++++++
 4 files changed

// File: rtl/riscv_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package riscv_fetch_queue_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_EXCEPT
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int unsigned DEPTH_DEFAULT    = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-side bundle: IMEM request/response, execute redirect/halt and decode handshake.
interface riscv_fetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        except_ia;

  // master is the fetch queue itself; slave is the surrounding IMEM/execute/decode side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, halt,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    output except_ia
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, halt,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    input  except_ia
  );
endinterface

// File: rtl/riscv_fetch_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; simultaneous push/pop allowed when full.
module riscv_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_l || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/riscv_fetch_queue.sv
// In-order instruction fetch: credit-limited IMEM issue, PC-tagged response queue, flush on redirect/halt.
module riscv_fetch_queue
  import riscv_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_l,
  riscv_fetch_queue_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW-1:0] tag_count;
  logic [CW:0]   credit_used;
  logic          except_q;

  logic          issue;
  logic          resp_take;
  logic          resp_keep;
  logic          flush;
  logic          misaligned;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic          tag_full;
  logic          tag_empty;
  logic [31:0]   tag_pc;
  fetch_entry_t  q_in;
  fetch_entry_t  q_out;

  assign credit_used = {1'b0, q_count} + {1'b0, inflight};

  assign bus.imem_req_valid = rst_l && (state == S_RUN) && !bus.redirect_valid
                              && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;

  assign issue         = bus.imem_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding (e.g. right after reset) is ignored entirely.
  assign resp_take     = bus.imem_resp_valid && (inflight != '0);
  assign flush         = (state == S_RUN) && (bus.halt || bus.redirect_valid);
  assign misaligned    = (bus.redirect_pc[1:0] != 2'b00);
  assign resp_keep     = resp_take && (drop_cnt == '0) && (state == S_RUN) && !flush;
  assign inflight_next = inflight + CW'(issue) - CW'(resp_take);

  assign bus.inst_valid = rst_l && !q_empty && (state != S_EXCEPT);
  assign bus.inst       = q_out.inst;
  assign bus.inst_pc    = q_out.pc;
  assign bus.except_ia  = except_q;
  assign q_pop          = bus.inst_valid && bus.inst_ready;

  assign q_in.inst = bus.imem_resp_data;
  assign q_in.pc   = tag_pc;

  riscv_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (issue),
    .pop   (resp_keep),
    .flush (flush),
    .din   (fetch_pc),
    .dout  (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  riscv_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_data_q (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (resp_keep),
    .pop   (q_pop),
    .flush (flush),
    .din   (q_in),
    .dout  (q_out),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state    <= S_RUN;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      except_q <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (resp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      // Flush: every fetch still outstanding after this cycle returns stale and must be dropped.
      unique case (state)
        S_RUN: begin
          if (bus.halt) begin
            state    <= S_HALT;
            drop_cnt <= inflight_next;
          end else if (bus.redirect_valid) begin
            drop_cnt <= inflight_next;
            fetch_pc <= bus.redirect_pc;
            if (misaligned) begin
              state    <= S_EXCEPT;
              except_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Credit rule keeps both FIFOs from overflowing; tags plus pending drops always equal inflight.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      assert (!(resp_keep && q_full));
      assert (!(issue && tag_full));
      assert (!(resp_keep && tag_empty));
      if (state == S_RUN) assert (({1'b0, tag_count} + {1'b0, drop_cnt}) == {1'b0, inflight});
    end
  end
endmodule
